// File: rtl/common_pkg.sv
// Shared bus and scalar types used across the pipeline and memory interfaces.
package common_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] u32;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic data_ok;
        u32   data;
    } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage payload types and pipeline-wide defaults.
package pipes_pkg;

    import common_pkg::*;

    localparam addr_t PC_RESET_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        u32 raw_instr;
    } instr_t;

    typedef struct packed {
        logic   valid;
        instr_t instr;
        addr_t  pc;
    } fetch_data_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding bus request, redirect handling, result held for decode.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_FETCH | request at req_addr outstanding, response will be kept
//   S_DROP  | request at req_addr outstanding but stale, response discarded
//   S_HOLD  | instruction presented on dataF until decode accepts it
module fetch_stage
    import common_pkg::*;
    import pipes_pkg::*;
#(
    parameter addr_t PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall,
    input  logic        redirect_valid,
    input  addr_t       redirect_pc,
    output fetch_data_t dataF
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t state, state_n;
    addr_t  pc, pc_n;
    addr_t  req_addr, req_addr_n;
    u32     out_instr, out_instr_n;
    addr_t  out_pc, out_pc_n;
    addr_t  seq_pc;

    assign seq_pc = out_pc + 64'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= PC_RESET;
            req_addr  <= PC_RESET;
            out_instr <= '0;
            out_pc    <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_addr  <= req_addr_n;
            out_instr <= out_instr_n;
            out_pc    <= out_pc_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        req_addr_n  = req_addr;
        out_instr_n = out_instr;
        out_pc_n    = out_pc;
        unique case (state)
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                    if (iresp.data_ok) begin
                        // Bus is free again: issue the redirect target right away.
                        req_addr_n = redirect_pc;
                    end else begin
                        state_n = S_DROP;
                    end
                end else if (iresp.data_ok) begin
                    out_instr_n = iresp.data;
                    out_pc_n    = req_addr;
                    state_n     = S_HOLD;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_n = redirect_pc;
                end
                if (iresp.data_ok) begin
                    req_addr_n = redirect_valid ? redirect_pc : pc;
                    state_n    = S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_n       = redirect_pc;
                    req_addr_n = redirect_pc;
                    state_n    = S_FETCH;
                end else if (!stall) begin
                    pc_n       = seq_pc;
                    req_addr_n = seq_pc;
                    state_n    = S_FETCH;
                end
            end
            default: state_n = S_FETCH;
        endcase
    end

    // Reset gates the bus request combinationally so an in-flight fetch is abandoned at once.
    always_comb begin
        ireq.valid            = !reset && (state != S_HOLD);
        ireq.addr             = req_addr;
        dataF.valid           = !reset && (state == S_HOLD);
        dataF.instr.raw_instr = out_instr;
        dataF.pc              = out_pc;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected dataF deliveries.
module tb_fetch_stage;

    import common_pkg::*;
    import pipes_pkg::*;

    typedef struct packed {
        addr_t pc;
        u32    instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stall;
    logic        redirect_valid;
    addr_t       redirect_pc;
    fetch_data_t dataF;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_valid = 1'b0;

    fetch_stage #(.PC_RESET(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dataF          (dataF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every new dataF delivery must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && dataF.valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_dataF_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_pc", dataF.pc, e.pc);
                check("sb_instr", {32'd0, dataF.instr.raw_instr}, {32'd0, e.instr});
            end
        end
        prev_valid <= dataF.valid;
    end

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iresp          = '0;
        tick();
        tick();
        check("rst_ireq_valid", {63'd0, ireq.valid}, 64'd0);
        check("rst_dataF_valid", {63'd0, dataF.valid}, 64'd0);
        check("rst_dataF_pc", dataF.pc, 64'd0);
        check("rst_dataF_instr", {32'd0, dataF.instr.raw_instr}, 64'd0);

        reset = 1'b0;
        #1;
        check("first_ireq_valid", {63'd0, ireq.valid}, 64'd1);
        check("first_ireq_addr", ireq.addr, 64'h8000_0000);

        // Basic fetch with 1-cycle response
        iresp = '{data_ok: 1'b1, data: 32'h0000_0013};
        sb_q.push_back('{pc: 64'h8000_0000, instr: 32'h0000_0013});
        tick();
        iresp = '0;
        check("hold_dataF_valid", {63'd0, dataF.valid}, 64'd1);
        check("hold_dataF_pc", dataF.pc, 64'h8000_0000);
        check("hold_ireq_valid", {63'd0, ireq.valid}, 64'd0);
        tick();
        check("next_ireq_addr", ireq.addr, 64'h8000_0004);
        check("next_ireq_valid", {63'd0, ireq.valid}, 64'd1);
        check("accept_dataF_valid", {63'd0, dataF.valid}, 64'd0);

        // Stall for 3 cycles in HOLD
        iresp = '{data_ok: 1'b1, data: 32'h00A0_0093};
        sb_q.push_back('{pc: 64'h8000_0004, instr: 32'h00A0_0093});
        tick();
        iresp = '0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {63'd0, dataF.valid}, 64'd1);
            check("stall_pc", dataF.pc, 64'h8000_0004);
            check("stall_instr", {32'd0, dataF.instr.raw_instr}, 64'h00A0_0093);
            check("stall_ireq_valid", {63'd0, ireq.valid}, 64'd0);
            tick();
        end
        check("stall_end_valid", {63'd0, dataF.valid}, 64'd1);
        stall = 1'b0;
        tick();
        check("post_stall_ireq_valid", {63'd0, ireq.valid}, 64'd1);
        check("post_stall_ireq_addr", ireq.addr, 64'h8000_0008);

        // Redirect during a 4-cycle bus wait
        tick();
        check("wait_addr_stable", ireq.addr, 64'h8000_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("drop_ireq_valid", {63'd0, ireq.valid}, 64'd1);
        check("drop_ireq_addr", ireq.addr, 64'h8000_0008);
        tick();
        iresp = '{data_ok: 1'b1, data: 32'hDEAD_BEEF};
        tick();
        iresp = '0;
        check("drop_no_valid", {63'd0, dataF.valid}, 64'd0);
        check("drop_next_addr", ireq.addr, 64'h8000_0100);

        // Redirect and data_ok in the same FETCH cycle
        iresp          = '{data_ok: 1'b1, data: 32'hBAD0_0001};
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        iresp          = '0;
        redirect_valid = 1'b0;
        check("same_cycle_no_valid", {63'd0, dataF.valid}, 64'd0);
        check("same_cycle_ireq_valid", {63'd0, ireq.valid}, 64'd1);
        check("same_cycle_addr", ireq.addr, 64'h8000_0200);

        // Redirect in HOLD wins over stall
        iresp = '{data_ok: 1'b1, data: 32'h0010_0113};
        sb_q.push_back('{pc: 64'h8000_0200, instr: 32'h0010_0113});
        tick();
        iresp          = '0;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        check("hold_redir_valid", {63'd0, dataF.valid}, 64'd0);
        check("hold_redir_addr", ireq.addr, 64'h8000_0300);

        // Two redirects while in DROP: latest wins
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0400;
        tick();
        redirect_pc    = 64'h8000_0500;
        tick();
        redirect_valid = 1'b0;
        iresp = '{data_ok: 1'b1, data: 32'hBAD0_0002};
        tick();
        iresp = '0;
        check("two_redir_no_valid", {63'd0, dataF.valid}, 64'd0);
        check("two_redir_addr", ireq.addr, 64'h8000_0500);
        iresp = '{data_ok: 1'b1, data: 32'h0020_0193};
        sb_q.push_back('{pc: 64'h8000_0500, instr: 32'h0020_0193});
        tick();
        iresp = '0;
        tick();
        check("after_B_addr", ireq.addr, 64'h8000_0504);

        // PC wrap at the top of the address space
        iresp          = '{data_ok: 1'b1, data: 32'hBAD0_0003};
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        iresp = '{data_ok: 1'b1, data: 32'h0030_0213};
        sb_q.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, instr: 32'h0030_0213});
        tick();
        iresp = '0;
        tick();
        check("wrap_addr", ireq.addr, 64'd0);
        check("wrap_ireq_valid", {63'd0, ireq.valid}, 64'd1);

        // Reset mid-transaction
        tick();
        reset = 1'b1;
        tick();
        check("midrst_ireq_valid", {63'd0, ireq.valid}, 64'd0);
        check("midrst_dataF_valid", {63'd0, dataF.valid}, 64'd0);
        check("midrst_dataF_pc", dataF.pc, 64'd0);
        reset = 1'b0;
        #1;
        check("restart_ireq_valid", {63'd0, ireq.valid}, 64'd1);
        check("restart_ireq_addr", ireq.addr, 64'h8000_0000);

        tick();
        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
